// File: rtl/led_matrix_scan_pwm.sv
// Column-scanned LED matrix driver with per-pixel PWM grey levels. LMD_TEARFREE_EN defers buffer loads to the frame boundary.
// Latency: serial inputs act on the 3rd clk edge after their rise; row_out/col_sel/frame_sync are registered and track the scan counters.
// Backpressure: none; the scan free-runs while ena=1 and holds position while ena=0.
module led_matrix_scan_pwm #(
    parameter int NCOLS       = 8,
    parameter int NROWS       = 8,
    parameter int PWM_BITS    = 2,
    parameter int SLOT_TICKS  = 8,
    parameter int BLANK_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             din,
    input  logic             dclk,
    input  logic             strobe,
    output logic [NROWS-1:0] row_out,
    output logic [NCOLS-1:0] col_sel,
    output logic             frame_sync
);
    localparam int S        = (1 << PWM_BITS) - 1;
    localparam int DWELL    = BLANK_TICKS + S * SLOT_TICKS;
    localparam int TOTAL    = NCOLS * NROWS * PWM_BITS;
    localparam int CB       = NROWS * PWM_BITS;
    localparam int CW       = $clog2(NCOLS);
    localparam int TW       = $clog2(DWELL);
    localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(DWELL - 1);

    logic [2:0]       sync1, sync2;   // {strobe, dclk, din}
    logic [1:0]       prev;           // {strobe, dclk} one cycle behind sync2
    logic             din_s, dclk_rise, strobe_rise;
    logic [TOTAL-1:0] chain, disp_buf;
    logic [CW-1:0]    col, col_nxt;
    logic [TW-1:0]    t, t_nxt;
    logic             wrap, load;
    logic [CB-1:0]    col_bits;
    logic [NROWS-1:0] row_nxt;
    logic [NCOLS-1:0] col_sel_nxt;

    assign din_s       = sync2[0];
    assign dclk_rise   = sync2[1] & ~prev[0];
    assign strobe_rise = sync2[2] & ~prev[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {strobe, dclk, din};
            sync2 <= sync1;
            prev  <= sync2[2:1];
        end
    end

    always_comb begin
        t_nxt   = t;
        col_nxt = col;
        wrap    = 1'b0;
        if (ena) begin
            if (t == T_LAST) begin
                t_nxt   = '0;
                col_nxt = (col == COL_LAST) ? '0 : col + CW'(1);
                wrap    = (col == COL_LAST);
            end else begin
                t_nxt = t + TW'(1);
            end
        end
    end

    // Outputs are computed from the next counter state so they line up with col/t once registered.
    // A pixel of value v is lit for t in [BLANK, BLANK + v*SLOT), i.e. exactly while v > slot index.
    always_comb begin
        col_bits = '0;
        for (int c = 0; c < NCOLS; c++) begin
            if (col_nxt == CW'(c)) col_bits = disp_buf[c*CB +: CB];
        end
        row_nxt     = '0;
        col_sel_nxt = '0;
        if (ena && (32'(t_nxt) >= BLANK_TICKS)) begin
            col_sel_nxt = NCOLS'(1) << col_nxt;
            for (int r = 0; r < NROWS; r++) begin
                row_nxt[r] = 32'(t_nxt) <
                             BLANK_TICKS + 32'(col_bits[r*PWM_BITS +: PWM_BITS]) * SLOT_TICKS;
            end
        end
    end

`ifdef LMD_TEARFREE_EN
    logic pending;

    // A strobe edge coincident with the frame wrap is honoured at that same wrap.
    assign load = wrap & (pending | strobe_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pending <= 1'b0;
        else if (load)        pending <= 1'b0;
        else if (strobe_rise) pending <= 1'b1;
    end
`else
    assign load = strobe_rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain      <= '0;
            disp_buf   <= '0;
            col        <= '0;
            t          <= '0;
            row_out    <= '0;
            col_sel    <= '0;
            frame_sync <= 1'b0;
        end else begin
            col        <= col_nxt;
            t          <= t_nxt;
            row_out    <= row_nxt;
            col_sel    <= col_sel_nxt;
            frame_sync <= wrap;
            if (dclk_rise) chain    <= {chain[TOTAL-2:0], din_s};
            if (load)      disp_buf <= chain;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_pwm.sv
// Bench for led_matrix_scan_pwm: frame-position model plus hand-computed directed checks.
module tb_led_matrix_scan_pwm;
    localparam int NC = 8, NR = 8, PB = 2, ST = 8, BT = 4;
    localparam int S     = (1 << PB) - 1;
    localparam int DW    = BT + S * ST;
    localparam int TOT   = NC * NR * PB;
    localparam int FRAME = NC * DW;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, din = 1'b0, dclk = 1'b0, strobe = 1'b0;
    logic [NR-1:0] row_out;
    logic [NC-1:0] col_sel;
    logic          frame_sync;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    led_matrix_scan_pwm #(
        .NCOLS(NC), .NROWS(NR), .PWM_BITS(PB), .SLOT_TICKS(ST), .BLANK_TICKS(BT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .dclk(dclk), .strobe(strobe),
        .row_out(row_out), .col_sel(col_sel), .frame_sync(frame_sync)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scan position is simply the number of enabled cycles since reset.
    logic [TOT-1:0] m_chain, m_buf;
    bit             m_pend;
    int             a;
    logic [NR-1:0]  e_row;
    logic [NC-1:0]  e_col;
    logic           e_fs;
    logic [2:0]     h_dclk, h_strb, h_din;   // bit0 = sample one edge ago

    task automatic model_step();
        logic drise, srise, wrap;
        int c, t;
        if (!rst_n) begin
            m_chain = '0; m_buf = '0; m_pend = 0; a = 0;
            e_row = '0; e_col = '0; e_fs = 1'b0;
            h_dclk = '0; h_strb = '0; h_din = '0;
            return;
        end
        // An input rise takes effect when the level from two edges ago is 1 and from three edges ago is 0.
        drise = h_dclk[1] & ~h_dclk[2];
        srise = h_strb[1] & ~h_strb[2];
        wrap  = 1'b0;
        e_row = '0; e_col = '0; e_fs = 1'b0;
        if (ena) begin
            a++;
            c    = (a / DW) % NC;
            t    = a % DW;
            wrap = (a % FRAME) == 0;
            e_fs = wrap;
            if (t >= BT) begin
                e_col = NC'(1) << c;
                for (int r = 0; r < NR; r++)
                    e_row[r] = int'(m_buf[(c*NR + r)*PB +: PB]) > (t - BT) / ST;
            end
        end
`ifdef LMD_TEARFREE_EN
        if (wrap && (m_pend || srise)) begin
            m_buf = m_chain; m_pend = 0;
        end else if (srise) begin
            m_pend = 1;
        end
`else
        if (srise) m_buf = m_chain;
`endif
        if (drise) m_chain = {m_chain[TOT-2:0], h_din[1]};
        h_dclk = {h_dclk[1:0], dclk};
        h_strb = {h_strb[1:0], strobe};
        h_din  = {h_din[1:0], din};
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("model row_out", 32'(row_out), 32'(e_row));
            check("model col_sel", 32'(col_sel), 32'(e_col));
            check("model frame_sync", 32'(frame_sync), 32'(e_fs));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic shift_image(input logic [TOT-1:0] img);
        for (int i = TOT - 1; i >= 0; i--) begin
            din = img[i];
            repeat (2) @(negedge clk);
            dclk = 1'b1;
            repeat (2) @(negedge clk);
            dclk = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        repeat (3) @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (frame_sync !== 1'b1 && n < 2 * FRAME);
        check(name, 32'(frame_sync), 32'd1);
    endtask

    task automatic wait_col(input string name, input logic [NC-1:0] want);
        int n = 0;
        do begin @(negedge clk); n++; end while (col_sel !== want && n < 2 * FRAME);
        check(name, 32'(col_sel), 32'(want));
    endtask

    initial begin
        logic [TOT-1:0] img;
        int nz;

        // Reset release with ena=1; cycle n is observed after the n-th rising edge.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        check("reset col_sel", 32'(col_sel), 32'd0);
        check("reset row_out", 32'(row_out), 32'd0);
        check("reset frame_sync", 32'(frame_sync), 32'd0);
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            if (n == 3)     check("cycle3 col_sel", 32'(col_sel), 32'h00);
            if (n == 4)     check("cycle4 col_sel", 32'(col_sel), 32'h01);
            if (n == 31)    check("cycle31 col_sel", 32'(col_sel), 32'h00);
            if (n == 32)    check("cycle32 col_sel", 32'(col_sel), 32'h02);
            if (n == 223)   check("cycle223 frame_sync", 32'(frame_sync), 32'd0);
            if (n == FRAME) check("cycle224 frame_sync", 32'(frame_sync), 32'd1);
        end

        // Only pixel (2,5) = 2'b10: lit for slots 0-1 of column 2.
        img = '0;
        img[43] = 1'b1;
        shift_image(img);
        pulse_strobe();
        wait_fs("px25 frame_sync");
        wait_col("px25 col2 reached", 8'h04);
        for (int i = 0; i < S * ST; i++) begin
            check($sformatf("px25 row_out t=%0d", i + BT), 32'(row_out), (i < 2 * ST) ? 32'h20 : 32'h00);
            @(negedge clk);
        end
        check("px25 blank col_sel", 32'(col_sel), 32'h00);
        check("px25 blank row_out", 32'(row_out), 32'h00);

        // Column 3: row1 = 3 (always on), row2 = 1 (slot 0 only), row6 = 0 (never).
        img = '0;
        img[51:50] = 2'b11;
        img[53:52] = 2'b01;
        shift_image(img);
        pulse_strobe();
        wait_fs("col3 frame_sync");
        wait_col("col3 reached", 8'h08);
        for (int i = 0; i < S * ST; i++) begin
            check("col3 row1 value3", 32'(row_out[1]), 32'd1);
            check("col3 row6 value0", 32'(row_out[6]), 32'd0);
            check("col3 row2 value1", 32'(row_out[2]), (i < ST) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("col3 blank row_out", 32'(row_out), 32'h00);

        // Random image, strobed wherever the shift happens to end in the frame.
        img = {$urandom, $urandom, $urandom, $urandom};
        shift_image(img);
        pulse_strobe();
        repeat (2 * FRAME) @(negedge clk);

        // Pause at column 5, t=10 for 50 cycles.
        wait_col("ena col5 reached", 8'h20);
        repeat (6) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("ena_off col_sel", 32'(col_sel), 32'h00);
            check("ena_off row_out", 32'(row_out), 32'h00);
        end
        ena = 1'b1;
        @(negedge clk);
        check("resume col_sel", 32'(col_sel), 32'h20);
        repeat (16) @(negedge clk);
        check("resume t27 col_sel", 32'(col_sel), 32'h20);
        @(negedge clk);
        check("resume col6 blank", 32'(col_sel), 32'h00);

        // Asynchronous reset mid-frame while a column is driven.
        wait_col("pre-reset col1", 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("async reset col_sel", 32'(col_sel), 32'h00);
        check("async reset row_out", 32'(row_out), 32'h00);
        check("async reset frame_sync", 32'(frame_sync), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nz = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (row_out != '0) nz++;
        end
        check("dark after reset", 32'(nz), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
